// File: rtl/subneg_sram_responder.sv
// subneg_sram_responder: on-chip address latch + byte SRAM for the SUBNEG bus, with a reset-time byte loader (option: SUBNEG_MEM_IOMAP_EN maps IO_ADDR to io_in/io_out)
module subneg_sram_responder #(
    parameter int         DEPTH   = 256,
    parameter logic [7:0] IO_ADDR = 8'd254
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       le,
    input  logic       oe_n,
    input  logic       we_n,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic       ld_en,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    output logic       ld_done,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {BUS, LOAD} state_t;

    state_t        r_state, w_state_nx;
    logic [7:0]    r_mem [DEPTH];
    logic [7:0]    r_addr, r_rd;
    logic          r_bus_oe, r_we_prev, r_ld_done;
    logic [AW-1:0] r_ld_ptr;
    logic          w_bus_wr, w_ld_wr, w_io_hit, w_mem_we;
    logic [AW-1:0] w_mem_idx;
    logic [7:0]    w_mem_din;

`ifdef SUBNEG_MEM_IOMAP_EN
    assign w_io_hit = (r_addr == IO_ADDR);
`else
    assign w_io_hit = 1'b0;
`endif

    // Mode register: the loader owns the memory whenever ld_en was sampled high
    always_ff @(posedge clk) begin
        r_state <= reset ? BUS : w_state_nx;
    end

    // Next mode, loader handshake and write-port arbitration; a write on a reset edge is dropped
    always_comb begin
        w_state_nx = ld_en ? LOAD : BUS;
        ld_ready   = (r_state == LOAD);
        w_bus_wr   = (r_state == BUS) & ~we_n & r_we_prev & oe_n & ~reset;
        w_ld_wr    = ld_ready & ld_valid & ~reset;
        w_mem_we   = w_ld_wr | (w_bus_wr & ~w_io_hit);
        w_mem_idx  = w_ld_wr ? r_ld_ptr : r_addr[AW-1:0];
        w_mem_din  = w_ld_wr ? ld_data : bus_in;
    end

    // Address latch, registered read, bus drive enable, strobe history and loader pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_rd      <= '0;
            r_bus_oe  <= 1'b0;
            r_we_prev <= 1'b1;
            r_ld_ptr  <= '0;
            r_ld_done <= 1'b0;
        end else begin
            if (r_state == BUS && le) r_addr <= bus_in;
            r_rd      <= w_io_hit ? io_in : r_mem[r_addr[AW-1:0]];
            r_bus_oe  <= ~oe_n & ~ld_en;
            r_we_prev <= we_n;
            if (w_ld_wr) r_ld_ptr <= r_ld_ptr + 1'b1;
            r_ld_done <= w_ld_wr & (&r_ld_ptr);
        end
    end

    // Storage array is never cleared so a loaded image survives reset
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_idx] <= w_mem_din;
    end

`ifdef SUBNEG_MEM_IOMAP_EN
    logic [7:0] r_io;

    // Core writes to the I/O address land in the output port instead of the array
    always_ff @(posedge clk) begin
        if (reset) r_io <= '0;
        else if (w_bus_wr && w_io_hit) r_io <= bus_in;
    end

    assign io_out = r_io;
`else
    assign io_out = '0;
`endif

    assign bus_out = r_rd;
    assign bus_oe  = r_bus_oe;
    assign ld_done = r_ld_done;
endmodule

// File: tb/tb_subneg_sram_responder.sv
// tb_subneg_sram_responder: randomized scoreboard bench for subneg_sram_responder against a behavioural memory model
module tb_subneg_sram_responder;
    logic       clk = 0, reset = 1, le = 0, oe_n = 1, we_n = 1, ld_en = 0, ld_valid = 0;
    logic [7:0] bus_in = 0, ld_data = 0, io_in = 0;
    logic [7:0] bus_out, io_out;
    logic       bus_oe, ld_ready, ld_done;

    int         errors = 0, checks = 0;
    logic [7:0] m_mem [256];
    logic [7:0] m_io = 0;
    int         m_ptr = 0;
    int         exp_done = 0;
    logic [7:0] exp_q[$];

`ifdef SUBNEG_MEM_IOMAP_EN
    localparam bit IOMAP = 1'b1;
`else
    localparam bit IOMAP = 1'b0;
`endif

    subneg_sram_responder dut (
        .clk(clk), .reset(reset), .le(le), .oe_n(oe_n), .we_n(we_n),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .ld_en(ld_en), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .io_in(io_in), .io_out(io_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
        return (IOMAP && a == 8'd254) ? io_in : m_mem[a];
    endfunction

    // Monitor: every cycle the responder drives the bus must match the oldest expected read
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_oe) begin
                if (exp_q.size() == 0) chk("unexpected_bus_oe", {7'd0, bus_oe}, 8'd0);
                else chk("rd_data", bus_out, exp_q.pop_front());
            end
            if (ld_done) begin
                if (exp_done == 0) chk("unexpected_ld_done", {7'd0, ld_done}, 8'd0);
                else begin
                    exp_done--;
                    chk("ld_done", {7'd0, ld_done}, 8'd1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a);
        le = 1; bus_in = a; step();
        le = 0; oe_n = 0; exp_q.push_back(exp_rd(a)); step();
        oe_n = 1; step();
        chk("bus_oe_drop", {7'd0, bus_oe}, 8'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input int hold);
        le = 1; bus_in = a; step();
        le = 0; bus_in = d; we_n = 0; step();
        for (int i = 1; i < hold; i++) begin
            bus_in = ~d; step();
        end
        we_n = 1; step();
        if (IOMAP && a == 8'd254) m_io = d;
        else m_mem[a] = d;
    endtask

    task automatic contend(input logic [7:0] a, input logic [7:0] d);
        le = 1; bus_in = a; step();
        le = 0; oe_n = 0; we_n = 0; bus_in = d; exp_q.push_back(exp_rd(a)); step();
        oe_n = 1; we_n = 1; step();
    endtask

    task automatic enter_load();
        ld_en = 1; step();
        chk("ld_ready_load", {7'd0, ld_ready}, 8'd1);
    endtask

    task automatic exit_load();
        ld_en = 0; ld_valid = 0; step();
        chk("ld_ready_bus", {7'd0, ld_ready}, 8'd0);
    endtask

    task automatic load_byte(input logic [7:0] b);
        if ($urandom_range(3) == 0) step();
        ld_valid = 1; ld_data = b; step();
        ld_valid = 0;
        m_mem[m_ptr] = b;
        m_ptr = (m_ptr + 1) % 256;
        if (m_ptr == 0) exp_done++;
    endtask

    task automatic reset_checks();
        step();
        chk("rst_bus_oe", {7'd0, bus_oe}, 8'd0);
        chk("rst_bus_out", bus_out, 8'd0);
        chk("rst_ld_ready", {7'd0, ld_ready}, 8'd0);
        chk("rst_ld_done", {7'd0, ld_done}, 8'd0);
        chk("rst_io_out", io_out, 8'd0);
        reset = 0; m_ptr = 0; m_io = 0;
        step();
    endtask

    initial begin
        step();
        reset_checks();
        enter_load();
        load_byte(8'h05); load_byte(8'h06); load_byte(8'h09);
        exit_load();
        rd(8'd0); rd(8'd1); rd(8'd2);
        enter_load();
        for (int i = 3; i < 256; i++) load_byte(8'($urandom));
        load_byte(8'h77);
        exit_load();
        rd(8'd0); rd(8'd255);
        rd(8'd6);
        wr(8'd6, 8'h2A, 3);
        rd(8'd6);
        contend(8'd6, 8'hC3);
        rd(8'd6);
        io_in = 8'hA3;
        wr(8'd254, 8'h55, 1);
        chk("io_out", io_out, m_io);
        rd(8'd254);
        for (int i = 0; i < 60; i++) begin
            logic [7:0] a, d;
            a = 8'($urandom); d = 8'($urandom); io_in = 8'($urandom);
            case ($urandom_range(2))
                0: rd(a);
                1: wr(a, d, int'($urandom_range(1, 3)));
                default: contend(a, d);
            endcase
        end
        chk("io_out_final", io_out, m_io);
        enter_load();
        for (int i = 0; i < 5; i++) load_byte(8'($urandom));
        ld_valid = 1; ld_data = 8'hEE; reset = 1; ld_en = 0; step();
        ld_valid = 0;
        reset_checks();
        for (int i = 1; i <= 6; i++) rd(8'(i));
        enter_load();
        load_byte(8'h99);
        exit_load();
        rd(8'd0);
        le = 1; bus_in = 8'h10; step();
        le = 0; bus_in = 8'hBB; we_n = 0; reset = 1; step();
        we_n = 1;
        reset_checks();
        rd(8'h10);
        step(); step();
        checks++;
        if (exp_q.size() != 0 || exp_done != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: reads left %0d, ld_done left %0d, required 0 and 0", exp_q.size(), exp_done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1);
    end
endmodule
